// File: rtl/seven_seg_pkg.sv
// Shared constants and the hex segment table for the 4-digit
// seven-segment decoder.
package seven_seg_pkg;

    localparam int DIGITS = 4;
    localparam int A_W    = 4;
    localparam int K_W    = 7;
    localparam int NIB_W  = 4;
    localparam int IDX_W  = 2;
    localparam int DATA_W = DIGITS * NIB_W;

    // Segment pattern for a hex digit; bit 6 is seg a, bit 0 is seg g.
    function automatic logic [K_W-1:0] seg_of(input logic [NIB_W-1:0] n);
        logic [K_W-1:0] s;
        case (n)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b1001110;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seven_seg_4d_decoder_lookup.sv
// Inverse segment lookup: maps a segment pattern back to its hex
// nibble, flagging patterns that are not in the table.
module seven_seg_lookup
    import seven_seg_pkg::*;
(
    input  logic [K_W-1:0]   k,
    output logic [NIB_W-1:0] nibble,
    output logic             hit
);

    // Search the table; an unknown pattern yields nibble 0 with no hit.
    always_comb begin
        nibble = '0;
        hit    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (k == seg_of(NIB_W'(i))) begin
                nibble = NIB_W'(i);
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_seg_4d_decoder.sv
// Recovers 4-digit hex frames from a multiplexed seven-segment
// display bus, with debounce, frame assembly and stale-frame timeout.
module seven_seg_4d_decoder
    import seven_seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [A_W-1:0]    a,
    input  logic [K_W-1:0]    k,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              err
);

    localparam logic [8:0]  STABLE_N  = 9'(STABLE_CYCLES);
    localparam logic [15:0] TIMEOUT_N = 16'(TIMEOUT_CYCLES);

    logic [A_W-1:0]    a_q;
    logic [K_W-1:0]    k_q;
    logic [A_W-1:0]    a_p;
    logic [K_W-1:0]    k_p;
    logic [7:0]        stab_q;
    logic [7:0]        stab_n;
    logic              done_q;
    logic              done_n;
    logic [DIGITS-1:0] mask_q;
    logic [DIGITS-1:0] mask_n;
    logic [DATA_W-1:0] nib_q;
    logic [DATA_W-1:0] nib_n;
    logic              ferr_q;
    logic              ferr_n;
    logic [15:0]       tcnt_q;
    logic [15:0]       tcnt_n;

    logic              one_hot;
    logic              multi;
    logic              same;
    logic [8:0]        cnt_eff;
    logic              done_eff;
    logic              accept;
    logic              publish;
    logic              timeout_hit;
    logic [IDX_W-1:0]  idx;
    logic [NIB_W-1:0]  dec_nib;
    logic              dec_hit;

    seven_seg_lookup u_lookup (
        .k      (k_q),
        .nibble (dec_nib),
        .hit    (dec_hit)
    );

    // Register the raw bus once, and keep the previous sample for
    // change detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            k_q <= '0;
            a_p <= '0;
            k_p <= '0;
        end else begin
            a_q <= a;
            k_q <= k;
            a_p <= a_q;
            k_p <= k_q;
        end
    end

    // Classify the registered sample and decide on acceptance.
    always_comb begin
        one_hot  = (a_q != '0) && ((a_q & (a_q - 1'b1)) == '0);
        multi    = (a_q != '0) && !one_hot;
        same     = ({a_q, k_q} == {a_p, k_p});
        cnt_eff  = same ? ({1'b0, stab_q} + 9'd1) : 9'd1;
        stab_n   = cnt_eff[8] ? 8'hFF : cnt_eff[7:0];
        done_eff = same && done_q;
        accept   = one_hot && !done_eff && (cnt_eff >= STABLE_N);
        done_n   = done_eff || accept;
    end

    // Digit index of the one-hot select.
    always_comb begin
        idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a_q[i]) idx = IDX_W'(i);
        end
    end

    // Timeout counter saturates and resets on every acceptance.
    always_comb begin
        publish     = (mask_q == '1);
        timeout_hit = 1'b0;
        tcnt_n      = tcnt_q;
        if (accept) begin
            tcnt_n = '0;
        end else if (tcnt_q != TIMEOUT_N) begin
            tcnt_n = tcnt_q + 16'd1;
            if (tcnt_n == TIMEOUT_N) timeout_hit = 1'b1;
        end
    end

    // Frame assembly: clear on publish or timeout, then merge this
    // cycle's contribution so it lands in the next frame.
    always_comb begin
        mask_n = mask_q;
        nib_n  = nib_q;
        ferr_n = ferr_q;
        if (publish || timeout_hit) begin
            mask_n = '0;
            nib_n  = '0;
            ferr_n = 1'b0;
        end
        if (accept) begin
            mask_n[idx] = 1'b1;
            nib_n[{idx, 2'b00} +: NIB_W] = dec_hit ? dec_nib : '0;
            if (!dec_hit) ferr_n = 1'b1;
        end
        if (multi) ferr_n = 1'b1;
    end

    // Stability, frame and timeout state.
    always_ff @(posedge clk) begin
        if (rst) begin
            stab_q <= '0;
            done_q <= 1'b0;
            mask_q <= '0;
            nib_q  <= '0;
            ferr_q <= 1'b0;
            tcnt_q <= '0;
        end else begin
            stab_q <= stab_n;
            done_q <= done_n;
            mask_q <= mask_n;
            nib_q  <= nib_n;
            ferr_q <= ferr_n;
            tcnt_q <= tcnt_n;
        end
    end

    // Publish a completed frame with a one-cycle valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            err   <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= publish;
            if (publish) begin
                data <= nib_q;
                err  <= ferr_q;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_4d_decoder.sv
// Randomised scoreboard bench for the 4-digit seven-segment decoder.
// Expected frames come from a sample-level reference model.
module tb_seven_seg_4d_decoder;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  a = '0;
    logic [6:0]  k = '0;
    logic [15:0] data;
    logic        valid;
    logic        err;

    seven_seg_4d_decoder #(
        .STABLE_CYCLES  (1),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .k     (k),
        .data  (data),
        .valid (valid),
        .err   (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int vcnt  = 0;

    logic [6:0] seg_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    typedef struct {
        logic [15:0] d;
        logic        e;
        int          at;
    } exp_t;

    exp_t q[$];

    int         m_nib [4];
    bit [3:0]   m_mask;
    bit         m_err;
    int         m_idle;
    logic [3:0] p_a;
    logic [6:0] p_k;

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_nib[i] = 0;
        m_mask = '0;
        m_err  = 1'b0;
    endtask

    task automatic model_reset();
        model_clear();
        m_idle = 0;
        p_a    = '0;
        p_k    = '0;
    endtask

    // One display sample per cycle, judged by the display rules.
    task automatic model(input logic [3:0] sa, input logic [6:0] sk,
                         input int at);
        bit acc;
        int d;
        int v;
        exp_t e;
        acc = ($countones(sa) == 1) && ({sa, sk} != {p_a, p_k});
        p_a = sa;
        p_k = sk;
        if (acc) begin
            d = 0;
            for (int i = 0; i < 4; i++) if (sa[i]) d = i;
            v = -1;
            for (int i = 0; i < 16; i++) if (seg_tab[i] == sk) v = i;
            m_nib[d] = (v < 0) ? 0 : v;
            if (v < 0) m_err = 1'b1;
            m_mask[d] = 1'b1;
            m_idle = 0;
            if (m_mask == 4'hF) begin
                e.d  = 16'(m_nib[3] * 4096 + m_nib[2] * 256
                           + m_nib[1] * 16 + m_nib[0]);
                e.e  = m_err;
                e.at = at + 3;
                q.push_back(e);
                model_clear();
            end
        end else begin
            if (m_idle < TMO) begin
                m_idle++;
                if (m_idle == TMO) model_clear();
            end
            if ($countones(sa) > 1) m_err = 1'b1;
        end
    endtask

    task automatic drive(input logic [3:0] sa, input logic [6:0] sk);
        @(posedge clk);
        #1;
        a = sa;
        k = sk;
        model(sa, sk, cyc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(4'b0000, 7'b0000000);
    endtask

    task automatic scan(input logic [15:0] v);
        logic [3:0] n;
        for (int d = 0; d < 4; d++) begin
            n = v[4*d +: 4];
            drive(4'(1 << d), seg_tab[n]);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        a   = '0;
        k   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_data", 32'(data), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);
    endtask

    // Monitor: every valid pulse must match the oldest expected frame.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                vcnt++;
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_valid cyc=%0d data=%h err=%b",
                             cyc, data, err);
                end else begin
                    e = q.pop_front();
                    if (data !== e.d || err !== e.e || cyc != e.at) begin
                        fails++;
                        $display("FAIL frame got data=%h err=%b cyc=%0d exp data=%h err=%b cyc=%0d",
                                 data, err, cyc, e.d, e.e, e.at);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        int v0;
        int r;
        logic [3:0] ra;
        logic [3:0] rn;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_data", 32'(data), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);

        scan(16'h1234);
        idle(6);
        check("frame_1234_seen", 32'(vcnt), 32'd1);
        check("frame_1234_data", 32'(data), 32'h1234);

        v0 = vcnt;
        for (int f = 0; f < 10; f++) scan(16'hA5F0);
        idle(6);
        check("a5f0_count", 32'(vcnt - v0), 32'd10);

        drive(4'b0001, seg_tab[1]);
        drive(4'b0010, seg_tab[2]);
        drive(4'b0100, 7'b1010101);
        drive(4'b1000, seg_tab[7]);
        idle(5);
        check("badk_nib", 32'(data[11:8]), 32'h0);
        check("badk_err", 32'(err), 32'h1);
        scan(16'h5678);
        idle(5);
        check("clean_err", 32'(err), 32'h0);

        drive(4'b0001, seg_tab[9]);
        drive(4'b0010, seg_tab[8]);
        drive(4'b0011, seg_tab[3]);
        drive(4'b0100, seg_tab[7]);
        drive(4'b1000, seg_tab[6]);
        idle(5);
        check("multi_data", 32'(data), 32'h6789);
        check("multi_err", 32'(err), 32'h1);

        v0 = vcnt;
        drive(4'b0001, seg_tab[1]);
        drive(4'b0010, seg_tab[2]);
        drive(4'b0100, seg_tab[3]);
        idle(TMO + 4);
        drive(4'b1000, seg_tab[4]);
        idle(6);
        check("timeout_no_valid", 32'(vcnt - v0), 32'd0);
        check("timeout_queue", 32'(q.size()), 32'd0);

        drive(4'b0001, seg_tab[15]);
        drive(4'b0010, seg_tab[14]);
        do_reset();
        scan(16'h0C0D);
        idle(5);
        check("post_rst_data", 32'(data), 32'h0C0D);
        check("post_rst_err", 32'(err), 32'h0);

        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                idle(TMO + 6);
            end else if (r < 55) begin
                rn = 4'($urandom_range(0, 15));
                drive(4'(1 << $urandom_range(0, 3)), seg_tab[rn]);
            end else if (r < 65) begin
                drive(4'(1 << $urandom_range(0, 3)), 7'($urandom));
            end else if (r < 80) begin
                idle(1);
            end else if (r < 88) begin
                ra = 4'($urandom);
                while ($countones(ra) < 2) ra = 4'($urandom);
                drive(ra, 7'($urandom));
            end else begin
                drive(a, k);
            end
        end
        idle(10);
        check("drain_queue", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seven_seg_4d_decoder.md
SEVEN_SEG_4D_DECODER -- requirements
Module: seven_seg_4d_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 1: consecutive identical samples of {a,k} required before a digit is accepted; legal range 1..255.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: cycles without an accepted digit before a partial frame is discarded; legal range 2..65535.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a  input  4  digit-select lines of a multiplexed 4-digit display; one-hot, a[i] selects digit i.
REQ-006 k  input  7  segment lines, k[6]=seg a through k[0]=seg g, active-high.
REQ-007 data  output  16  last complete frame; digit i occupies data[4i+3:4i].
REQ-008 valid  output  1  one-cycle pulse marking a data update.
REQ-009 err  output  1  set with data when the published frame contained any invalid sample.

Function
REQ-010 Inputs a and k shall be registered once before any decision; no combinational path from input to output.
REQ-011 A registered sample is a candidate when a is one-hot; a==0 is idle and ignored without error.
REQ-012 A multi-hot a shall be ignored for capture and shall set the frame error flag.
REQ-013 A candidate shall be accepted after STABLE_CYCLES consecutive identical registered {a,k} values; with STABLE_CYCLES=1 every candidate is accepted on the cycle it is registered.
REQ-014 While {a,k} stays unchanged after acceptance, it shall not be re-accepted; a new acceptance requires a change in {a,k}.
REQ-015 An accepted sample shall decode k through the 16-entry hex table into the nibble for digit i and set bit i of a 4-bit captured mask.
REQ-016 A k pattern not in the table shall store nibble 0, set mask bit i, and set the frame error flag.
REQ-017 A repeated digit before frame completion shall overwrite its nibble (latest wins).
REQ-018 When the mask reaches 4'b1111, data and err shall update and valid shall pulse on the next edge; the mask, stored nibbles and frame error flag shall clear on that same edge.
REQ-019 Latency: with STABLE_CYCLES=1, valid is high in the cycle starting 3 rising edges after the edge at which the completing {a,k} is first present at the inputs.
REQ-020 An acceptance coinciding with frame publication shall count toward the next frame.
REQ-021 data and err shall hold between valid pulses.
REQ-022 A 16-bit counter shall count cycles since the last acceptance; on reaching TIMEOUT_CYCLES the mask, nibbles and frame error flag shall clear, with no valid pulse, and the counter shall saturate until the next acceptance.

Reset
REQ-023 On rst: data=16'h0000, valid=0, err=0, mask=0, nibbles=0, frame error flag=0, stability and timeout counters=0, input registers=0.
REQ-024 Reset mid-frame shall discard the partial frame; the first valid after reset shall reflect only digits accepted after reset release.

Structure
REQ-025 Shared package seven_seg_pkg shall hold the hex segment table (0:1111110 1:0110000 2:1101101 3:1111001 4:0110011 5:1011011 6:1011111 7:1110000 8:1111111 9:1111011 A:1110111 b:0011111 C:1001110 d:0111101 E:1001111 F:1000111), the digit count 4, and widths of a and k.
REQ-026 The inverse lookup shall be one combinational sub-module, seven_seg_lookup (in: k; out: nibble, hit).

Verification
REQ-027 Scan 16'h1234 as a=0001/k=0110011, a=0010/k=1111001, a=0100/k=1101101, a=1000/k=0110000, one digit per cycle -> data=16'h4321 is wrong; bench digit order shall yield data=16'h1234 only when a[0] carries 4, i.e. data[3:0]=4; valid one cycle per frame, err=0, latency per REQ-019.
REQ-028 Continuous scan of 16'hA5F0 for 10 frames -> 10 valid pulses spaced 4 cycles, each data=16'hA5F0, err=0.
REQ-029 Frame with digit 2 k=1010101 -> valid with data[11:8]=0, err=1; next clean frame -> err=0.
REQ-030 a=0011 inserted mid-frame -> no capture from that sample, frame publishes with err=1.
REQ-031 Three digits then a=0000 for TIMEOUT_CYCLES -> no valid; subsequent single digit does not complete a frame.
REQ-032 rst asserted after two digits of 16'hBEEF, released, full scan of 16'h0C0D -> data=16'h0C0D, err=0, no stale nibbles.
